// File: rtl/flap_pkg.sv
// Shared definitions for the flappy-bird score/game-over block: default
// geometry and the game state encoding.
package flap_pkg;

    // Default geometry, in pixels unless noted.
    localparam int FLAP_COORD_W   = 11;
    localparam int FLAP_NUM_PIPES = 2;
    localparam int FLAP_SCORE_W   = 8;
    localparam int FLAP_BIRD_W    = 16;
    localparam int FLAP_BIRD_H    = 16;
    localparam int FLAP_PIPE_W    = 40;
    localparam int FLAP_GAP_H     = 120;
    localparam int FLAP_SCREEN_H  = 480;

    // Game state encoding; exported on the debug state output.
    typedef enum logic [1:0] {
        FLAP_IDLE = 2'd0,
        FLAP_PLAY = 2'd1,
        FLAP_OVER = 2'd2
    } flap_state_e;

endpackage

// File: rtl/flap_score_fsm_if.sv
// Signal bundle between the motion blocks, the score/game-over FSM and the
// HUD renderer.
//
// Protocol: there is no valid/ready backpressure on this bundle. game_start,
// game_reset and frame_tick are single-cycle strobes sampled on the rising
// clock edge; the positions are sampled on the same edge as frame_tick. All
// results (score, flags, state_dbg) are registered and change on that edge.
interface flap_score_fsm_if #(
    parameter int COORD_W   = 11,
    parameter int NUM_PIPES = 2,
    parameter int SCORE_W   = 8
);
    logic                           game_start;
    logic                           game_reset;
    logic                           frame_tick;
    logic [COORD_W-1:0]             bird_x;
    logic [COORD_W-1:0]             bird_y;
    logic [NUM_PIPES*COORD_W-1:0]   pipe_x;
    logic [NUM_PIPES*COORD_W-1:0]   pipe_gap_y;

    logic [SCORE_W-1:0]             score;
    logic [SCORE_W-1:0]             highscore;
    logic                           new_highscore;
    logic                           gameover;
    logic                           playing;
    logic                           score_pulse;
    logic [1:0]                     state_dbg;

    // Producer side: motion blocks / testbench.
    modport master (
        output game_start, game_reset, frame_tick,
        output bird_x, bird_y, pipe_x, pipe_gap_y,
        input  score, highscore, new_highscore, gameover, playing,
        input  score_pulse, state_dbg
    );

    // Consumer side: the score FSM.
    modport slave (
        input  game_start, game_reset, frame_tick,
        input  bird_x, bird_y, pipe_x, pipe_gap_y,
        output score, highscore, new_highscore, gameover, playing,
        output score_pulse, state_dbg
    );
endinterface

// File: rtl/flap_pipe_check.sv
// One pipe channel: collision test against the bird box, pass detection,
// and the per-pipe "already scored" flag that stops double counting.
module flap_pipe_check #(
    parameter int COORD_W = 11,
    parameter int BIRD_W  = 16,
    parameter int BIRD_H  = 16,
    parameter int PIPE_W  = 40,
    parameter int GAP_H   = 120
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] bird_x,
    input  logic [COORD_W-1:0] bird_y,
    input  logic [COORD_W-1:0] pipe_x,
    input  logic [COORD_W-1:0] gap_y,
    input  logic               set_en,
    input  logic               rearm_en,
    input  logic               flush,
    output logic               pass,
    output logic               hit
);
    // One extra bit so edge sums near the screen limit never wrap.
    localparam int CW = COORD_W + 1;

    logic [CW-1:0] bx_e, by_e, px_e, gy_e;
    logic [CW-1:0] pipe_r, bird_r, bird_b, gap_b;
    logic          passed_q;
    logic          rearm, xhit, yout;

    assign bx_e   = {1'b0, bird_x};
    assign by_e   = {1'b0, bird_y};
    assign px_e   = {1'b0, pipe_x};
    assign gy_e   = {1'b0, gap_y};
    assign pipe_r = px_e + CW'(PIPE_W);
    assign bird_r = bx_e + CW'(BIRD_W);
    assign bird_b = by_e + CW'(BIRD_H);
    assign gap_b  = gy_e + CW'(GAP_H);

    // Pass/collision geometry from the current positions.
    always_comb begin
        rearm = (pipe_r >= bx_e);
        pass  = (pipe_r < bx_e) && !passed_q;
        xhit  = (bx_e < pipe_r) && (bird_r > px_e);
        yout  = (by_e < gy_e) || (bird_b > gap_b);
        hit   = xhit && yout;
    end

    // Scored flag: set once the pipe is behind the bird, cleared when the
    // pipe respawns to the right so it can score again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            passed_q <= 1'b0;
        end else if (flush) begin
            passed_q <= 1'b0;
        end else if (set_en && pass) begin
            passed_q <= 1'b1;
        end else if (rearm_en && rearm) begin
            passed_q <= 1'b0;
        end
    end
endmodule

// File: rtl/flap_score_fsm.sv
// Game state machine (IDLE/PLAY/OVER), per-frame scoring and collision for
// one bird against NUM_PIPES pipes, plus a high score kept across games.
module flap_score_fsm
    import flap_pkg::*;
#(
    parameter int COORD_W   = FLAP_COORD_W,
    parameter int NUM_PIPES = FLAP_NUM_PIPES,
    parameter int SCORE_W   = FLAP_SCORE_W,
    parameter int BIRD_W    = FLAP_BIRD_W,
    parameter int BIRD_H    = FLAP_BIRD_H,
    parameter int PIPE_W    = FLAP_PIPE_W,
    parameter int GAP_H     = FLAP_GAP_H,
    parameter int SCREEN_H  = FLAP_SCREEN_H
) (
    input  logic             clock,
    input  logic             reset,
    flap_score_fsm_if.slave  bus
);
    localparam int CW = COORD_W + 1;

    localparam logic [1:0] ST_IDLE = FLAP_IDLE;
    localparam logic [1:0] ST_PLAY = FLAP_PLAY;
    localparam logic [1:0] ST_OVER = FLAP_OVER;

    localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

    logic [1:0]           state_q;
    logic [SCORE_W-1:0]   score_q;
    logic [SCORE_W-1:0]   highscore_q;
    logic                 new_hs_q;
    logic                 pulse_q;

    logic [NUM_PIPES-1:0] pass_v;
    logic [NUM_PIPES-1:0] hit_v;
    logic                 floor_hit;
    logic                 crash;
    logic                 upd;
    logic [SCORE_W:0]     pass_sum;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;

    // Passed flags move only on a clean (non-crash) frame while playing.
    assign upd = (state_q == ST_PLAY) && bus.frame_tick && !crash && !bus.game_reset;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
            flap_pipe_check #(
                .COORD_W (COORD_W),
                .BIRD_W  (BIRD_W),
                .BIRD_H  (BIRD_H),
                .PIPE_W  (PIPE_W),
                .GAP_H   (GAP_H)
            ) u_pipe (
                .clock    (clock),
                .reset    (reset),
                .bird_x   (bus.bird_x),
                .bird_y   (bus.bird_y),
                .pipe_x   (bus.pipe_x[gi*COORD_W +: COORD_W]),
                .gap_y    (bus.pipe_gap_y[gi*COORD_W +: COORD_W]),
                .set_en   (upd),
                .rearm_en (upd),
                .flush    (bus.game_reset),
                .pass     (pass_v[gi]),
                .hit      (hit_v[gi])
            );
        end
    endgenerate

    // Crash detection: floor or any pipe body; the ceiling is harmless.
    always_comb begin
        floor_hit = ({1'b0, bus.bird_y} + CW'(BIRD_H)) >= CW'(SCREEN_H);
        crash     = floor_hit || (|hit_v);
    end

    // Saturating score increment by the number of pipes passed this frame.
    always_comb begin
        pass_sum = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pass_sum = pass_sum + {{SCORE_W{1'b0}}, pass_v[i]};
        end
        score_sum  = {1'b0, score_q} + pass_sum;
        score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    // Game state, score, high score and event pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            highscore_q <= '0;
            new_hs_q    <= 1'b0;
            pulse_q     <= 1'b0;
        end else if (bus.game_reset) begin
            state_q  <= ST_IDLE;
            score_q  <= '0;
            new_hs_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A tick arriving with the start pulse is not evaluated.
                    if (bus.game_start) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (bus.frame_tick) begin
                        if (crash) begin
                            state_q <= ST_OVER;
                            if (score_q > highscore_q) begin
                                highscore_q <= score_q;
                                new_hs_q    <= 1'b1;
                            end
                        end else begin
                            score_q <= score_next;
                            pulse_q <= |pass_v;
                        end
                    end
                end
                ST_OVER: begin
                    state_q <= ST_OVER;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.score         = score_q;
    assign bus.highscore     = highscore_q;
    assign bus.new_highscore = new_hs_q;
    assign bus.score_pulse   = pulse_q;
    assign bus.playing       = (state_q == ST_PLAY);
    assign bus.gameover      = (state_q == ST_OVER);
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_flap_score_fsm.sv
// Bench for flap_score_fsm: directed game scenarios followed by random play,
// checked against an integer reference model through an expected queue.
module tb_flap_score_fsm;
    localparam int CW = 11;
    localparam int NP = 2;
    localparam int SW = 8;
    localparam int EW = 2 * SW + 4;

    logic clock;
    logic reset;

    flap_score_fsm_if #(.COORD_W(CW), .NUM_PIPES(NP), .SCORE_W(SW)) bus ();

    flap_score_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- counters and scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q[$];
    string         lbl_q[$];

    // ---------------- reference model state ----------------
    int m_mode;   // 0 idle, 1 play, 2 over
    int m_score;
    int m_hs;
    bit m_nh;
    bit m_pulse;
    bit m_passed[NP];

    // Current stimulus positions (plain integers).
    int bx, by;
    int px[NP];
    int gy[NP];

    function automatic logic [EW-1:0] model_vec();
        logic [SW-1:0] s, h;
        s = SW'(m_score);
        h = SW'(m_hs);
        return {s, h, m_nh, (m_mode == 2), (m_mode == 1), m_pulse};
    endfunction

    function automatic logic [EW-1:0] dut_vec();
        return {bus.score, bus.highscore, bus.new_highscore,
                bus.gameover, bus.playing, bus.score_pulse};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got score=%0d hs=%0d nh=%b go=%b pl=%b sp=%b, expected score=%0d hs=%0d nh=%b go=%b pl=%b sp=%b",
                     name, act[EW-1 -: SW], act[EW-SW-1 -: SW], act[3], act[2], act[1], act[0],
                     expv[EW-1 -: SW], expv[EW-SW-1 -: SW], expv[3], expv[2], expv[1], expv[0]);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_hs = 0; m_nh = 0; m_pulse = 0;
        for (int i = 0; i < NP; i++) m_passed[i] = 0;
    endtask

    // Game rules in plain integer arithmetic.
    task automatic model_step(input bit gs, input bit gr, input bit ft);
        bit crash;
        int n;
        m_pulse = 0;
        if (gr) begin
            m_mode = 0; m_score = 0; m_nh = 0;
            for (int i = 0; i < NP; i++) m_passed[i] = 0;
            return;
        end
        if (m_mode == 0) begin
            if (gs) m_mode = 1;
        end else if (m_mode == 1 && ft) begin
            crash = (by + 16 >= 480);
            for (int i = 0; i < NP; i++) begin
                if (bx < px[i] + 40 && bx + 16 > px[i] &&
                    (by < gy[i] || by + 16 > gy[i] + 120)) crash = 1;
            end
            if (crash) begin
                m_mode = 2;
                if (m_score > m_hs) begin
                    m_hs = m_score;
                    m_nh = 1;
                end
            end else begin
                n = 0;
                for (int i = 0; i < NP; i++) begin
                    if (px[i] + 40 < bx) begin
                        if (!m_passed[i]) begin
                            n++;
                            m_passed[i] = 1;
                        end
                    end else begin
                        m_passed[i] = 0;
                    end
                end
                m_score = (m_score + n > 255) ? 255 : m_score + n;
                m_pulse = (n > 0);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit gs, input bit gr, input bit ft, input string lbl);
        @(negedge clock);
        bus.game_start = gs;
        bus.game_reset = gr;
        bus.frame_tick = ft;
        bus.bird_x     = CW'(bx);
        bus.bird_y     = CW'(by);
        for (int i = 0; i < NP; i++) begin
            bus.pipe_x[i*CW +: CW]     = CW'(px[i]);
            bus.pipe_gap_y[i*CW +: CW] = CW'(gy[i]);
        end
        model_step(gs, gr, ft);
        exp_q.push_back(model_vec());
        lbl_q.push_back(lbl);
    endtask

    // Pipes in mask go 70 -> 59 over two ticks (re-arm, then pass); others sit far right.
    task automatic pass_pipes(input logic [NP-1:0] mask, input string lbl);
        for (int i = 0; i < NP; i++) px[i] = mask[i] ? 70 : 640;
        step(0, 0, 1, {lbl, "_arm"});
        for (int i = 0; i < NP; i++) px[i] = mask[i] ? 59 : 640;
        step(0, 0, 1, {lbl, "_pass"});
    endtask

    task automatic safe_pose();
        bx = 100; by = 200;
        for (int i = 0; i < NP; i++) begin
            px[i] = 640;
            gy[i] = 150;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        string l;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                l = lbl_q.pop_front();
                check(l, dut_vec(), e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset          = 1'b0;
        bus.game_start = 1'b0;
        bus.game_reset = 1'b0;
        bus.frame_tick = 1'b0;
        bus.bird_x     = '0;
        bus.bird_y     = '0;
        bus.pipe_x     = '0;
        bus.pipe_gap_y = '0;
        safe_pose();
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_state", dut_vec(), model_vec());
        reset = 1'b1;

        // Idle behaviour and start pulse coinciding with a tick.
        step(0, 0, 0, "idle");
        step(0, 0, 1, "idle_tick_ignored");
        px[0] = 59;
        step(1, 0, 1, "start_with_tick");

        // Single scoring and re-arm.
        pass_pipes(2'b01, "score1");
        step(0, 0, 0, "pulse_drop");
        px[0] = 50;
        step(0, 0, 1, "no_double_score");
        px[0] = 640;
        step(0, 0, 1, "respawn");
        px[0] = 59;
        step(0, 0, 1, "score2");
        pass_pipes(2'b01, "score3");
        pass_pipes(2'b11, "dual_to5");
        pass_pipes(2'b01, "score6");
        while (m_score < 254) pass_pipes(2'b11, "dual_climb");
        pass_pipes(2'b11, "saturate");
        pass_pipes(2'b11, "saturate_pulse");

        // Reset keeps highscore (still 0, no crash yet); reset beats start.
        step(0, 1, 0, "game_reset1");
        step(1, 1, 0, "reset_beats_start");
        step(1, 0, 0, "start2");
        for (int k = 0; k < 4; k++) pass_pipes(2'b01, "to4");

        // Pipe crash at score 4.
        bx = 100; by = 50; px[0] = 90; gy[0] = 200; px[1] = 640;
        step(0, 0, 1, "pipe_crash");
        step(1, 0, 1, "over_holds");
        step(0, 1, 0, "game_reset2");
        safe_pose();
        step(1, 0, 0, "start3");
        for (int k = 0; k < 4; k++) pass_pipes(2'b01, "again4");
        px[1] = 70;
        step(0, 0, 1, "arm_pipe1");
        by = 470; px[1] = 59;
        step(0, 0, 1, "floor_crash_priority");
        step(0, 0, 0, "over_idle");

        // Asynchronous reset mid-game.
        step(0, 1, 0, "game_reset3");
        safe_pose();
        step(1, 0, 0, "start4");
        for (int k = 0; k < 5; k++) pass_pipes(2'b01, "to5");
        step(0, 0, 0, "settle");
        @(negedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_reset", dut_vec(), model_vec());
        @(negedge clock);
        reset = 1'b1;

        // Random play.
        step(1, 0, 0, "rand_start");
        for (int k = 0; k < 800; k++) begin
            bx = $urandom_range(60, 200);
            by = $urandom_range(0, 470);
            for (int i = 0; i < NP; i++) begin
                px[i] = $urandom_range(0, 700);
                gy[i] = $urandom_range(0, 360);
            end
            step($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 1) == 1, "random");
        end

        step(0, 0, 0, "drain");
        repeat (3) @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
